// File: rtl/pin_bus_target.sv
// pin_bus_target: memory-side endpoint of the 8-bit pin bus.
// Deserialises a sync/address/write-data frame, issues one 32-bit memory
// request, and serialises read data back onto the return lane in R0..R3.
// The host never stalls, so a slow memory is cut off at the end of the
// turnaround window and answered with TIMEOUT_DATA plus a sticky err.
module pin_bus_target #(
  parameter int          TURN         = 2,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr_in,
  input  logic [7:0]  wdata_in,
  input  logic        we_in,
  output logic [7:0]  rdata_out,
  output logic        rdata_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [3:0] {IDLE, A1, A2, A3, TRN, R0, R1, R2, R3} state_t;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tcnt;
  logic            last_turn;
  logic            sync;
  logic            dir;
  logic [1:0][7:0] ab;     // address bytes 1..2 (byte 3 taken live at A3)
  logic [2:0][7:0] wb;     // write bytes 0..2 (byte 3 taken live at A3)
  mem_req_t        req_q;
  logic [31:0]     ret;
  logic [7:0]      ret_byte;
  logic            in_ret;

  assign sync      = (addr_in == 8'hFF);
  assign last_turn = (state == TRN) && (tcnt == TW'(TURN - 1));
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: only IDLE looks for sync, so 0xFF inside a frame is data
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sync) state_nx = A1;
      A1:      state_nx = A2;
      A2:      state_nx = A3;
      A3:      state_nx = TRN;
      TRN:     if (last_turn) state_nx = R0;
      R0:      state_nx = R1;
      R1:      state_nx = R2;
      R2:      state_nx = R3;
      R3:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Turnaround counter, restarted as the request is launched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        tcnt <= '0;
    else if (state == A3)              tcnt <= '0;
    else if (state == TRN && !last_turn) tcnt <= tcnt + TW'(1);
  end

  // Frame capture: direction and byte 0 at sync, then bytes 1..2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= 1'b0;
      ab  <= '0;
      wb  <= '0;
    end else begin
      case (state)
        IDLE: if (sync) begin
          dir   <= we_in;
          wb[0] <= wdata_in;
        end
        A1: begin
          ab[0] <= addr_in;
          wb[1] <= wdata_in;
        end
        A2: begin
          ab[1] <= addr_in;
          wb[2] <= wdata_in;
        end
        default: ;
      endcase
    end
  end

  // Memory handshake: launch leaving A3, retire on ready or on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req <= 1'b0;
      req_q   <= '0;
      ret     <= '0;
      err     <= 1'b0;
    end else if (state == A3) begin
      mem_req <= 1'b1;
      req_q   <= {dir, addr_in, ab[1], ab[0], wdata_in, wb[2], wb[1], wb[0]};
    end else if (mem_req && mem_ready) begin
      mem_req <= 1'b0;
      ret     <= mem_rdata;
    end else if (mem_req && last_turn) begin
      mem_req <= 1'b0;
      ret     <= TIMEOUT_DATA;
      err     <= 1'b1;
    end
  end

  // Byte of the return register belonging to the current slot
  always_comb begin
    ret_byte = 8'h00;
    in_ret   = 1'b1;
    case (state)
      R0:      ret_byte = ret[7:0];
      R1:      ret_byte = ret[15:8];
      R2:      ret_byte = ret[23:16];
      R3:      ret_byte = ret[31:24];
      default: in_ret   = 1'b0;
    endcase
  end

  // Registered return lane: one edge behind the slot, driven for reads only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_out <= 8'h00;
      rdata_oe  <= 1'b0;
    end else if (in_ret && !dir) begin
      rdata_out <= ret_byte;
      rdata_oe  <= 1'b1;
    end else begin
      rdata_out <= 8'h00;
      rdata_oe  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pin_bus_target.sv
// Directed bench for pin_bus_target: one task per scenario, a negedge
// monitor logging return bytes, request launches and request-high cycles.
module tb_pin_bus_target;

  localparam int TURN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr_in = '0, wdata_in = '0;
  logic        we_in = 1'b0;
  logic [7:0]  rdata_out;
  logic        rdata_oe, mem_req, mem_we, mem_ready = 1'b0, err;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;

  int nvec = 0, nerr = 0;

  pin_bus_target #(.TURN(TURN), .TIMEOUT_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .wdata_in(wdata_in),
    .we_in(we_in), .rdata_out(rdata_out), .rdata_oe(rdata_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // monitor logs
  logic [7:0]  rbytes [0:63];
  logic [23:0] alog   [0:15];
  logic [31:0] wlog   [0:15];
  logic        welog  [0:15];
  int rb_n = 0, an = 0, req_cyc = 0, stray = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    if (rdata_oe && rb_n < 64) begin rbytes[rb_n] = rdata_out; rb_n++; end
    if (!rdata_oe && rdata_out != 8'h00) stray++;
    if (mem_req) req_cyc++;
    if (mem_req && !req_prev && an < 16) begin
      alog[an] = mem_addr; wlog[an] = mem_wdata; welog[an] = mem_we; an++;
    end
    req_prev = mem_req;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      addr_in = 0; wdata_in = 0; we_in = 0; mem_ready = 0; mem_rdata = 0;
    end
  endtask

  // Drives ncyc cycles of a frame starting at S; ready in TURN cycle rdy (0 = never)
  task automatic drive_frame(input logic we, input logic [7:0] a1, a2, a3,
                             input logic [31:0] wd, input int rdy,
                             input logic [31:0] rd, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      addr_in = 0; wdata_in = 0; we_in = 0; mem_ready = 0; mem_rdata = 0;
      if (c == 0) begin addr_in = 8'hFF; wdata_in = wd[7:0]; we_in = we; end
      if (c == 1) begin addr_in = a1; wdata_in = wd[15:8]; end
      if (c == 2) begin addr_in = a2; wdata_in = wd[23:16]; end
      if (c == 3) begin addr_in = a3; wdata_in = wd[31:24]; end
      if (rdy > 0 && c == 3 + rdy) begin mem_ready = 1; mem_rdata = rd; end
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {rbytes[i+3], rbytes[i+2], rbytes[i+1], rbytes[i]};
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nvec++;
    if ({rdata_out, rdata_oe, mem_req, mem_we, err} !== 12'h000) begin
      nerr++; $display("FAIL reset_ctl: got %h want 000", {rdata_out, rdata_oe, mem_req, mem_we, err});
    end
    nvec++;
    if ({mem_addr, mem_wdata} !== 56'h0) begin
      nerr++; $display("FAIL reset_bus: got %h want 0", {mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_zero_wait;
    int r0 = rb_n, a0 = an, q0 = req_cyc;
    drive_frame(0, 8'h12, 8'h34, 8'h56, 0, 1, 32'hA1B2C3D4, 8 + TURN);
    idle(2);
    nvec++; if (an - a0 !== 1) begin nerr++; $display("FAIL rd_launches: got %0d want 1", an - a0); end
    nvec++; if (alog[a0] !== 24'h563412) begin nerr++; $display("FAIL rd_addr: got %h want 563412", alog[a0]); end
    nvec++; if (welog[a0] !== 1'b0) begin nerr++; $display("FAIL rd_we: got %b want 0", welog[a0]); end
    nvec++; if (req_cyc - q0 !== 1) begin nerr++; $display("FAIL rd_req_cycles: got %0d want 1", req_cyc - q0); end
    nvec++; if (rb_n - r0 !== 4) begin nerr++; $display("FAIL rd_oe_cycles: got %0d want 4", rb_n - r0); end
    nvec++; if (word_at(r0) !== 32'hA1B2C3D4) begin nerr++; $display("FAIL rd_bytes: got %h want a1b2c3d4", word_at(r0)); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rd_err: got %b want 0", err); end
  endtask

  task automatic test_write;
    int r0 = rb_n, a0 = an, s0 = stray;
    drive_frame(1, 8'h01, 8'h02, 8'h03, 32'h44332211, 1, 32'hDEADBEEF, 8 + TURN);
    idle(2);
    nvec++; if (welog[a0] !== 1'b1) begin nerr++; $display("FAIL wr_we: got %b want 1", welog[a0]); end
    nvec++; if (wlog[a0] !== 32'h44332211) begin nerr++; $display("FAIL wr_wdata: got %h want 44332211", wlog[a0]); end
    nvec++; if (alog[a0] !== 24'h030201) begin nerr++; $display("FAIL wr_addr: got %h want 030201", alog[a0]); end
    nvec++; if (rb_n - r0 !== 0) begin nerr++; $display("FAIL wr_oe: got %0d want 0", rb_n - r0); end
    nvec++; if (stray - s0 !== 0) begin nerr++; $display("FAIL wr_rdata_zero: got %0d want 0", stray - s0); end
  endtask

  task automatic test_embedded_ff;
    int r0 = rb_n, a0 = an, q0 = req_cyc;
    // ready in the last turnaround cycle still counts as a completion
    drive_frame(0, 8'hFF, 8'hFF, 8'hFF, 0, TURN, 32'h5A6B7C8D, 8 + TURN);
    idle(4);
    nvec++; if (an - a0 !== 1) begin nerr++; $display("FAIL ff_launches: got %0d want 1", an - a0); end
    nvec++; if (alog[a0] !== 24'hFFFFFF) begin nerr++; $display("FAIL ff_addr: got %h want ffffff", alog[a0]); end
    nvec++; if (req_cyc - q0 !== TURN) begin nerr++; $display("FAIL ff_req_cycles: got %0d want %0d", req_cyc - q0, TURN); end
    nvec++; if (rb_n - r0 !== 4) begin nerr++; $display("FAIL ff_oe_cycles: got %0d want 4", rb_n - r0); end
    nvec++; if (word_at(r0) !== 32'h5A6B7C8D) begin nerr++; $display("FAIL ff_bytes: got %h want 5a6b7c8d", word_at(r0)); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL ff_err: got %b want 0", err); end
  endtask

  task automatic test_timeout;
    int r0 = rb_n, q0 = req_cyc, r1;
    // ready arrives in R0, after the cutoff, and must be ignored
    drive_frame(0, 8'hAA, 8'hBB, 8'hCC, 0, TURN + 1, 32'h12345678, 8 + TURN);
    idle(2);
    nvec++; if (req_cyc - q0 !== TURN) begin nerr++; $display("FAIL to_req_cycles: got %0d want %0d", req_cyc - q0, TURN); end
    nvec++; if (word_at(r0) !== 32'hFFFFFFFF) begin nerr++; $display("FAIL to_bytes: got %h want ffffffff", word_at(r0)); end
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL to_err: got %b want 1", err); end
    r1 = rb_n;
    drive_frame(0, 8'h01, 8'h02, 8'h03, 0, 1, 32'hCAFEF00D, 8 + TURN);
    idle(2);
    nvec++; if (word_at(r1) !== 32'hCAFEF00D) begin nerr++; $display("FAIL to_next_bytes: got %h want cafef00d", word_at(r1)); end
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL to_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_frame;
    int r0, a0;
    drive_frame(0, 8'h21, 8'h22, 8'h23, 0, 0, 0, 5);  // stop in first TURN cycle
    #2;
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL rst_pre_req: got %b want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rst_async_req: got %b want 0", mem_req); end
    nvec++;
    if ({rdata_oe, mem_we, err, mem_addr} !== 27'h0) begin
      nerr++; $display("FAIL rst_async_regs: got %h want 0", {rdata_oe, mem_we, err, mem_addr});
    end
    @(negedge clk); rst_n = 1'b1;
    r0 = rb_n; a0 = an;
    drive_frame(0, 8'h09, 8'h08, 8'h07, 0, 1, 32'h0BADF00D, 8 + TURN);
    idle(2);
    nvec++; if (alog[a0] !== 24'h070809) begin nerr++; $display("FAIL rst_next_addr: got %h want 070809", alog[a0]); end
    nvec++; if (word_at(r0) !== 32'h0BADF00D) begin nerr++; $display("FAIL rst_next_bytes: got %h want 0badf00d", word_at(r0)); end
  endtask

  task automatic test_back_to_back;
    int r0 = rb_n, a0 = an;
    drive_frame(0, 8'h10, 8'h20, 8'h30, 0, 1, 32'h11223344, 8 + TURN);
    drive_frame(0, 8'h40, 8'h50, 8'h60, 0, 2, 32'h55667788, 8 + TURN);
    idle(2);
    nvec++; if (an - a0 !== 2) begin nerr++; $display("FAIL b2b_launches: got %0d want 2", an - a0); end
    nvec++; if (alog[a0] !== 24'h302010) begin nerr++; $display("FAIL b2b_addr0: got %h want 302010", alog[a0]); end
    nvec++; if (alog[a0+1] !== 24'h605040) begin nerr++; $display("FAIL b2b_addr1: got %h want 605040", alog[a0+1]); end
    nvec++; if (rb_n - r0 !== 8) begin nerr++; $display("FAIL b2b_oe_cycles: got %0d want 8", rb_n - r0); end
    nvec++; if (word_at(r0) !== 32'h11223344) begin nerr++; $display("FAIL b2b_bytes0: got %h want 11223344", word_at(r0)); end
    nvec++; if (word_at(r0+4) !== 32'h55667788) begin nerr++; $display("FAIL b2b_bytes1: got %h want 55667788", word_at(r0+4)); end
  endtask

  initial begin
    test_reset;
    idle(2);
    test_read_zero_wait;
    test_write;
    test_embedded_ff;
    test_timeout;
    test_reset_mid_frame;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pin_bus_target.md
# pin_bus_target

Memory-side endpoint of the 8-bit pin bus that the CPU handler uses to carry its 32-bit bus off-chip. It sits directly downstream of the handler's pin outputs and upstream of its pin inputs. It deserialises one framed transfer (sync/address/write-data bytes), issues a single 32-bit request on a valid/ready memory port, and serialises the 32-bit read data back onto the return lane in fixed return slots. Frame timing is dictated by the host and never stalls, so late memory responses are handled by timeout and a sticky error flag.

## Interface
- `TURN`, default 2: turnaround cycles between the last address byte and the first return slot. The host's turnaround must match this value.
- `TIMEOUT_DATA`, default 32'hFFFF_FFFF: value returned on a read that times out.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `addr_in` in 8: host address lane. Carries 8'hFF for sync, then address bytes 1..3.
- `wdata_in` in 8: host data lane. Carries write bytes 0..3 during S, A1, A2, A3.
- `we_in` in 1: host direction. 1 = write, 0 = read. Sampled at S only.
- `rdata_out` out 8: return-lane byte.
- `rdata_oe` out 1: return-lane drive enable.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: request is a write.
- `mem_addr` out 24: word address, {A3 byte, A2 byte, A1 byte}.
- `mem_wdata` out 32: write data, {byte3, byte2, byte1, byte0}.
- `mem_ready` in 1: memory accepts/completes the request in this cycle.
- `mem_rdata` in 32: read data, valid while `mem_ready`=1.
- `err` out 1: sticky timeout flag. Cleared only by reset.

## Operation
- FSM states: IDLE → S → A1 → A2 → A3 → TURN(×TURN) → R0 → R1 → R2 → R3 → IDLE.
- IDLE
  - Stays in IDLE until `addr_in`==8'hFF.
  - In that cycle, latches `wdata_in` into wdata[7:0] and `we_in` into the direction register, and moves to A1.
  - The sampling cycle itself counts as S.
- A1, A2, A3
  - Latch `addr_in` into address bytes 1, 2, 3.
  - Latch `wdata_in` into wdata bytes 1, 2, 3.
  - 8'hFF on `addr_in` after S is treated as address data, never as a resync.
- Memory request
  - `mem_req` rises on the clock edge that leaves A3. `mem_addr`, `mem_wdata` and `mem_we` are stable from that edge.
  - `mem_req` stays high until it is sampled together with `mem_ready`=1, or until the timeout.
- Read completion
  - On `mem_ready`=1 while `mem_req`=1, `mem_rdata` is latched into the return register and `mem_req` drops next edge.
- Timeout
  - Timeout occurs if `mem_ready` has not been seen by the last TURN cycle.
  - At the R0 edge: `mem_req` drops, the return register loads `TIMEOUT_DATA`, and `err` sets.
  - `mem_ready` arriving after the timeout is ignored.
- Return slots R0..R3
  - Drive return bytes [7:0], [15:8], [23:16], [31:24] respectively on `rdata_out`.
  - `rdata_oe`=1 in R0..R3 for reads only.
- Writes
  - `rdata_oe` stays 0 and `rdata_out` holds 0.
  - A write timeout still sets `err`.
- After R3, the FSM returns to IDLE. A sync in the cycle immediately after R3 (first IDLE cycle) is accepted. Back-to-back frames therefore need no idle gap beyond that.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE. `rdata_out`=0, `rdata_oe`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err`=0.
- Reset mid-frame aborts the frame immediately and drops `mem_req` without a handshake. The memory must tolerate a withdrawn request.
- Frame length is 8+TURN cycles from S to R3 inclusive.
- Memory budget: `mem_req` is high for at most TURN cycles. A ready in the first TURN cycle is a zero-wait response.
- `rdata_out` and `rdata_oe` are registered. Values appear one edge after entering each R state, aligned with the host's sampling cycle (host samples the return lane one cycle after it shifts the slot).
- `mem_ready` while `mem_req`=0 is ignored.

## Test plan
- Read, zero-wait:
  - Stimulus: addr lane FF,12,34,56; we_in=0; mem_ready in TURN cycle 1 with mem_rdata=32'hA1B2C3D4.
  - Required: `mem_addr`=24'h563412, `mem_req` high exactly 1 cycle, return bytes D4,C3,B2,A1 in R0..R3, `rdata_oe` high for 4 cycles, `err`=0.
- Write:
  - Stimulus: sync with we_in=1, wdata lane 11,22,33,44.
  - Required: `mem_we`=1, `mem_wdata`=32'h44332211, `rdata_oe`=0 throughout.
- Timeout:
  - Stimulus: read with `mem_ready` never asserted.
  - Required: `mem_req` drops at R0, return bytes FF,FF,FF,FF, `err`=1 and still 1 after a following good frame.
- Embedded 0xFF:
  - Stimulus: address bytes FF,FF,FF.
  - Required: single frame, `mem_addr`=24'hFFFFFF, no resync.
- Reset mid-frame:
  - Stimulus: `rst_n` low during TURN with `mem_req`=1.
  - Required: `mem_req`=0 asynchronously, state IDLE, next sync frame completes normally.
- Back-to-back:
  - Stimulus: two read frames, second sync on the first IDLE cycle after R3.
  - Required: both frames' address and data are correct.
